// File: rtl/axi_lite_write_master.sv
// AXI-Lite write master: buffers user write commands in a FIFO, issues AW/W
// independently, and returns BRESP in order. Define AXIL_WR_ERR_CNT_EN for err_count.
module axi_lite_write_master #(
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 64,
  parameter  int CMD_DEPTH       = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int STRB_W          = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              idle
`ifdef AXIL_WR_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  cmd_t          mem [CMD_DEPTH];
  cmd_t          head;
  cmd_t          issue_cmd;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          ready_en;
  logic          empty, full, push, pop;
  logic [OW-1:0] outstanding;
  logic          b_hs;
  state_t        state_q, state_d;
  logic          aw_valid_d, w_valid_d, load;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = ready_en && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[PW-1:0]];
  // An empty FIFO forwards the command being pushed so AW/W rise the next cycle.
  assign issue_cmd = empty ? cmd_t'{cmd_addr, cmd_data, cmd_strb} : head;

  assign BREADY = !rsp_valid || rsp_ready;
  assign b_hs   = BVALID && BREADY && (outstanding != '0);
  assign idle   = empty && (outstanding == '0) && !rsp_valid;

  // NOTE: the storage array carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= cmd_t'{cmd_addr, cmd_data, cmd_strb};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = AWVALID;
    w_valid_d  = WVALID;
    load       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((!empty || push) && (outstanding < OW'(MAX_OUTSTANDING))) begin
          load       = 1'b1;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (AWVALID && AWREADY) aw_valid_d = 1'b0;
        if (WVALID && WREADY)   w_valid_d  = 1'b0;
        // Entry retires only once both channels have handshaken.
        if (!aw_valid_d && !w_valid_d) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      AWADDR  <= '0;
      WDATA   <= '0;
      WSTRB   <= '0;
    end else begin
      state_q <= state_d;
      AWVALID <= aw_valid_d;
      WVALID  <= w_valid_d;
      if (load) begin
        AWADDR <= issue_cmd.addr;
        WDATA  <= issue_cmd.data;
        WSTRB  <= issue_cmd.strb;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      outstanding <= '0;
    end else begin
      unique case ({pop, b_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // BREADY is low while a response is parked, so a new B never overwrites one.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
    end else if (b_hs) begin
      rsp_valid <= 1'b1;
      rsp_resp  <= BRESP;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef AXIL_WR_ERR_CNT_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_count <= '0;
    end else if (b_hs && BRESP[1] && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Self-checking bench for axi_lite_write_master: scoreboarded AW/W/response
// checks, a table of vectors, and directed multi-cycle corner cases.
module tb_axi_lite_write_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic        idle;
`ifdef AXIL_WR_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  axi_lite_write_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .idle(idle)
`ifdef AXIL_WR_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } cmd_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  cmd_t       exp_aw[$];
  cmd_t       exp_w[$];
  logic [1:0] exp_rsp[$];
  logic [1:0] resp_plan[$];
  int         aw_n = 0, w_n = 0, b_n = 0, rsp_n = 0;
  bit         slave_on = 1'b1;
  bit         b_en = 1'b1;
  bit         rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  // Monitor: handshakes are visible at the falling edge preceding the rising edge.
  initial begin
    cmd_t c;
    forever begin
      @(negedge ACLK);
      if (ARESETn) begin
        if (AWVALID && AWREADY) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
          else begin
            c = exp_aw.pop_front();
            check("awaddr", AWADDR, c.addr);
          end
          aw_n++;
        end
        if (WVALID && WREADY) begin
          if (exp_w.size() == 0) check("w_unexpected", 1, 0);
          else begin
            c = exp_w.pop_front();
            check("wdata", WDATA, c.data);
            check("wstrb", WSTRB, c.strb);
          end
          w_n++;
        end
        if (slave_on && BVALID && BREADY) b_n++;
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
          else check("rsp_resp", rsp_resp, exp_rsp.pop_front());
          rsp_n++;
        end
      end
    end
  end

  // Slave: returns one B per completed AW+W pair, with the planned response.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (slave_on) begin
        BVALID = ARESETn && b_en && (((aw_n < w_n) ? aw_n : w_n) > b_n);
        BRESP  = (b_n < resp_plan.size()) ? resp_plan[b_n] : 2'b00;
      end
      if (rand_rdy) begin
        AWREADY   = 1'($urandom_range(0, 1));
        WREADY    = 1'($urandom_range(0, 1));
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic [1:0] r);
    cmd_t c;
    c.addr = a; c.data = d; c.strb = s;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s;
    for (int i = 0; i < 200 && !cmd_ready; i++) tick();
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      exp_aw.push_back(c);
      exp_w.push_back(c);
      exp_rsp.push_back(r);
      resp_plan.push_back(r);
    end else begin
      cmd_valid = 1'b0;
    end
    tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && !(idle && exp_rsp.size() == 0); i++) tick();
    check({name, "_idle"}, idle, 1);
    check({name, "_rsp_left"}, exp_rsp.size(), 0);
  endtask

  vec_t vecs[8];
  int   aw0, w0, rsp0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 64'h0000_0000_0000_0001, 8'hFF, 2'b00};
    vecs[1] = '{32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 2'b10};
    vecs[2] = '{32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 2'b01};
    vecs[3] = '{32'h0000_0400, 64'hA5A5_5A5A_A5A5_5A5A, 8'h0F, 2'b11};
    vecs[4] = '{32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'h00, 2'b00};
    vecs[5] = '{32'h0000_0008, 64'h8000_0000_0000_0000, 8'h80, 2'b00};
    vecs[6] = '{32'h5555_AAAA, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C, 2'b10};
    vecs[7] = '{32'h0000_0010, 64'hFFFF_0000_FFFF_0000, 8'hC3, 2'b00};

    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    rsp_ready = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
    #1;
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_idle", idle, 1);
    check("rst_awaddr", AWADDR, 0);
    check("rst_wdata", WDATA, 0);
    tick(); tick();
    ARESETn = 1'b1;
    check("rel_cmd_ready_before_edge", cmd_ready, 0);
    tick();
    check("rel_cmd_ready_after_edge", cmd_ready, 1);

    // Single write, all ready: valids rise the cycle after the push.
    cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_data = 64'h1122_3344_5566_7788; cmd_strb = 8'hFF;
    check("single_awvalid_push_cycle", AWVALID, 0);
    exp_aw.push_back('{32'h10, 64'h1122_3344_5566_7788, 8'hFF});
    exp_w.push_back('{32'h10, 64'h1122_3344_5566_7788, 8'hFF});
    exp_rsp.push_back(2'b00); resp_plan.push_back(2'b00);
    tick();
    cmd_valid = 1'b0;
    check("single_awvalid_n1", AWVALID, 1);
    check("single_wvalid_n1", WVALID, 1);
    check("single_idle_busy", idle, 0);
    rsp0 = rsp_n;
    drain("single");
    check("single_rsp_count", rsp_n - rsp0, 1);

    // AWREADY held low 5 cycles, WREADY high.
    AWREADY = 1'b0; WREADY = 1'b1;
    aw0 = aw_n; w0 = w_n;
    send(32'h200, 64'h0BAD_F00D_0000_1111, 8'hF0, 2'b00);
    cmd_valid = 1'b0;
    check("awstall_awvalid", AWVALID, 1);
    check("awstall_wvalid", WVALID, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("awstall_w_dropped", WVALID, 0);
      check("awstall_aw_held", AWVALID, 1);
      check("awstall_awaddr_held", AWADDR, 32'h200);
    end
    AWREADY = 1'b1;
    tick();
    check("awstall_aw_dropped", AWVALID, 0);
    drain("awstall");
    check("awstall_aw_count", aw_n - aw0, 1);
    check("awstall_w_count", w_n - w0, 1);

    // Table of vectors back-to-back with randomly toggling readies.
    rand_rdy = 1'b1;
    rsp0 = rsp_n;
    foreach (vecs[i]) send(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
    cmd_valid = 1'b0;
    drain("table");
    check("table_rsp_count", rsp_n - rsp0, 8);
    rand_rdy = 1'b0;
    tick();
    AWREADY = 1'b1; WREADY = 1'b1; rsp_ready = 1'b1;

    // Six back-to-back commands with B withheld: two issue, four queue, FIFO full.
    b_en = 1'b0;
    aw0 = aw_n; rsp0 = rsp_n;
    for (int i = 0; i < 6; i++) send(32'h1000 + 32'(i * 8), 64'(i) * 64'h0101_0101_0101_0101, 8'hFF, 2'b00);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("outstd_aw_count", aw_n - aw0, 2);
    check("outstd_cmd_ready_full", cmd_ready, 0);
    check("outstd_awvalid_blocked", AWVALID, 0);
    b_en = 1'b1;
    drain("outstd");
    check("outstd_aw_total", aw_n - aw0, 6);
    check("outstd_rsp_count", rsp_n - rsp0, 6);

    // Response back-pressure: BREADY low while a response is parked.
    rsp_ready = 1'b0;
    send(32'h300, 64'h1, 8'h01, 2'b00);
    send(32'h308, 64'h2, 8'h02, 2'b01);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !(rsp_valid && BVALID); i++) tick();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_bvalid", BVALID, 1);
    check("bp_bready_low", BREADY, 0);
    check("bp_rsp_resp", rsp_resp, 2'b00);
    tick(); tick(); tick();
    check("bp_rsp_held", rsp_valid, 1);
    check("bp_resp_held", rsp_resp, 2'b00);
    rsp_ready = 1'b1;
    drain("bp");

    // Reset pulsed mid-burst.
    AWREADY = 1'b0;
    send(32'h400, 64'h44, 8'hFF, 2'b00);
    send(32'h408, 64'h55, 8'hFF, 2'b00);
    cmd_valid = 1'b0;
    check("midrst_awvalid_pre", AWVALID, 1);
    check("midrst_idle_pre", idle, 0);
    ARESETn = 1'b0;
    #1;
    check("midrst_awvalid", AWVALID, 0);
    check("midrst_wvalid", WVALID, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_idle", idle, 1);
    check("midrst_cmd_ready", cmd_ready, 0);
    exp_aw.delete(); exp_w.delete(); exp_rsp.delete(); resp_plan.delete();
    aw_n = 0; w_n = 0; b_n = 0; rsp_n = 0;
    BVALID = 1'b0;
    AWREADY = 1'b1;
    tick();
    check("midrst_cmd_ready_held", cmd_ready, 0);
    ARESETn = 1'b1;
    tick();
    check("midrst_cmd_ready_rel", cmd_ready, 1);
    check("midrst_idle_rel", idle, 1);
    check("midrst_no_reissue", AWVALID, 0);

    // Spurious BVALID with nothing outstanding is ignored.
    slave_on = 1'b0;
    BVALID = 1'b1; BRESP = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_b_rsp_valid", rsp_valid, 0);
      check("stray_b_idle", idle, 1);
      check("stray_b_bready", BREADY, 1);
    end
    BVALID = 1'b0;
    slave_on = 1'b1;

    // Error responses.
    send(32'h500, 64'h66, 8'hFF, 2'b10);
    send(32'h508, 64'h77, 8'hFF, 2'b11);
    cmd_valid = 1'b0;
    drain("err");
    check("err_rsp_count", rsp_n, 2);
`ifdef AXIL_WR_ERR_CNT_EN
    check("err_count", err_count, 16'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_write_master.md
AXI_LITE_WRITE_MASTER -- requirements
Module: axi_lite_write_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width (32 or 64); strobe width STRB_W = DATA_W/8, derived, not overridable.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth (power of two, >= 2).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, maximum issued writes awaiting B (>= 1).
REQ-005 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port ARESETn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  in  1  user write command valid.
REQ-008 SHALL have port cmd_ready  out  1  command FIFO can accept.
REQ-009 SHALL have port cmd_addr  in  ADDR_W  command address.
REQ-010 SHALL have port cmd_data  in  DATA_W  command write data.
REQ-011 SHALL have port cmd_strb  in  STRB_W  command byte strobes.
REQ-012 SHALL have port rsp_valid  out  1  write response available to user.
REQ-013 SHALL have port rsp_ready  in  1  user accepts response.
REQ-014 SHALL have port rsp_resp  out  2  BRESP of completed write.
REQ-015 SHALL have ports AWADDR out ADDR_W, AWVALID out 1, AWREADY in 1: AXI-Lite write address channel.
REQ-016 SHALL have ports WDATA out DATA_W, WSTRB out STRB_W, WVALID out 1, WREADY in 1: AXI-Lite write data channel.
REQ-017 SHALL have ports BRESP in 2, BVALID in 1, BREADY out 1: AXI-Lite write response channel.
REQ-018 SHALL have port idle  out  1  FIFO empty, zero outstanding, rsp_valid low.

Function
REQ-019 SHALL push {addr,data,strb} into the FIFO on cmd_valid && cmd_ready; cmd_ready = FIFO not full, with no combinational dependence on cmd_valid.
REQ-020 SHALL permit push and pop in the same cycle when the FIFO is neither empty nor full; read/write pointers wrap modulo CMD_DEPTH.
REQ-021 SHALL drive AWADDR/WDATA/WSTRB registered from the FIFO head; a command pushed in cycle N SHALL raise AWVALID and WVALID no earlier than N+1.
REQ-022 SHALL start issuing the head entry only when FIFO is non-empty and outstanding < MAX_OUTSTANDING.
REQ-023 SHALL handshake AW and W independently: AWVALID drops the cycle after AWVALID&&AWREADY, WVALID the cycle after WVALID&&WREADY, in either order or simultaneously.
REQ-024 SHALL, once asserted, hold AWVALID/WVALID and their payloads stable until the respective handshake, never withdrawing on any other condition except reset.
REQ-025 SHALL pop the head entry and increment outstanding in the cycle both AW and W handshakes are complete; the next entry may be issued the following cycle.
REQ-026 SHALL decrement outstanding on BVALID&&BREADY; simultaneous increment and decrement leave it unchanged; width $clog2(MAX_OUTSTANDING+1).
REQ-027 SHALL drive BREADY = !rsp_valid || rsp_ready, and on B handshake load rsp_resp = BRESP and set rsp_valid the next cycle.
REQ-028 SHALL hold rsp_valid and rsp_resp until rsp_ready; responses are delivered in command order.
REQ-029 SHALL ignore BVALID when outstanding == 0 (BREADY still as REQ-027; no counter underflow).

Reset
REQ-030 SHALL, while ARESETn low, force AWVALID, WVALID, rsp_valid, outstanding, FIFO pointers to 0, AWADDR/WDATA/WSTRB/rsp_resp to 0, cmd_ready to 0, idle to 1.
REQ-031 SHALL, on reset assertion mid-transaction, drop all valids immediately and discard queued and outstanding commands; cmd_ready rises on the first clock edge after release.

Configuration
REQ-032 SHALL, when macro AXIL_WR_ERR_CNT_EN is defined, add output err_count (16 bits, reset 0) incrementing on each B handshake with BRESP[1]=1, saturating at 16'hFFFF.
REQ-033 SHALL, when AXIL_WR_ERR_CNT_EN is undefined, omit port err_count and its logic, all other behaviour unchanged.

Verification
REQ-034 SHALL cover: one command addr=0x10, data=0x1122334455667788, strb=0xFF, ready always high -> AW/W valid cycle N+1, one B OKAY, rsp_resp=2'b00, idle returns 1.
REQ-035 SHALL cover: AWREADY held low 5 cycles while WREADY high -> WVALID drops after 1 cycle, AWVALID/AWADDR stable 5 cycles, single pop.
REQ-036 SHALL cover: 6 back-to-back commands, BVALID withheld -> exactly 2 AW issued, cmd_ready low after 4+2 queued... specifically after FIFO holds 4, no third AW until first B.
REQ-037 SHALL cover: rsp_ready low with rsp_valid high and BVALID high -> BREADY low, response not lost; rsp_ready high -> responses in order.
REQ-038 SHALL cover: BRESP=2'b10 then 2'b11 with AXIL_WR_ERR_CNT_EN -> err_count=2; ARESETn pulsed mid-burst -> all valids 0 same cycle, idle=1.
